// File: rtl/ball_collision_engine.sv
// Multi-ball equal-mass elastic collision resolver: walks every ball pair once per frame
// and swaps the normal velocity components of touching, approaching pairs.
module ball_collision_engine #(
  parameter int NUM_BALLS     = 4,
  parameter int W             = 11,
  parameter int BALL_DIAMETER = 16,
  parameter int NW            = 4*W+2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [NUM_BALLS-1:0]   ballActive,
  input  logic [NUM_BALLS*W-1:0] ballPosX,
  input  logic [NUM_BALLS*W-1:0] ballPosY,
  input  logic [NUM_BALLS*W-1:0] ballVelX,
  input  logic [NUM_BALLS*W-1:0] ballVelY,
  output logic [NUM_BALLS*W-1:0] ballVelXOut,
  output logic [NUM_BALLS*W-1:0] ballVelYOut,
  output logic [NUM_BALLS-1:0]   collisionMask,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int CW = $clog2(NW);
  localparam logic signed [NW-1:0] DIAM2  = NW'(BALL_DIAMETER * BALL_DIAMETER);
  localparam logic signed [W-1:0]  VMAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  VMIN_W = ~VMAX_W;
  localparam logic signed [NW:0]   VMAX   = (NW+1)'(VMAX_W);
  localparam logic signed [NW:0]   VMIN   = (NW+1)'(VMIN_W);

  typedef enum logic [2:0] {IDLE, LOAD, PAIR, TEST, DIVX, DIVY, UPDATE, DONE} state_t;

  state_t state, state_nx;

  logic [IW-1:0]        pi, pj;
  logic signed [W-1:0]  pos_x [NUM_BALLS];
  logic signed [W-1:0]  pos_y [NUM_BALLS];
  logic signed [W-1:0]  vel_x [NUM_BALLS];
  logic signed [W-1:0]  vel_y [NUM_BALLS];
  logic signed [W:0]    dx_r, dy_r;
  logic signed [NW-1:0] d2_r, k_r, qx, qy;

  logic [NW-1:0]        div_rem, div_quo, div_den;
  logic                 div_neg;
  logic [CW-1:0]        div_cnt;

  logic signed [W:0]    dx_c, dy_c, dvx_c, dvy_c;
  logic signed [NW-1:0] dx_w, dy_w, dvx_w, dvy_w, rdx_w, rdy_w;
  logic signed [NW-1:0] k_c, d2_c, num_x, num_y;
  logic [NW-1:0]        abs_x, abs_y;
  logic [NW:0]          rem_sh, rem_diff;
  logic                 rem_ge;
  logic [NW-1:0]        rem_nx, quo_nx;
  logic signed [NW-1:0] q_res;
  logic signed [NW:0]   vix_s, viy_s, vjx_s, vjy_s;
  logic                 hit, at_end, advance, div_last;

  function automatic logic signed [W-1:0] sat(input logic signed [NW:0] v);
    if (v > VMAX) return VMAX_W;
    else if (v < VMIN) return VMIN_W;
    return v[W-1:0];
  endfunction

  // Pair geometry and closing speed, widened so no product can overflow NW bits
  always_comb begin
    dx_c  = {pos_x[pj][W-1], pos_x[pj]} - {pos_x[pi][W-1], pos_x[pi]};
    dy_c  = {pos_y[pj][W-1], pos_y[pj]} - {pos_y[pi][W-1], pos_y[pi]};
    dvx_c = {vel_x[pj][W-1], vel_x[pj]} - {vel_x[pi][W-1], vel_x[pi]};
    dvy_c = {vel_y[pj][W-1], vel_y[pj]} - {vel_y[pi][W-1], vel_y[pi]};
    dx_w  = NW'(dx_c);
    dy_w  = NW'(dy_c);
    dvx_w = NW'(dvx_c);
    dvy_w = NW'(dvy_c);
    k_c   = dvx_w * dx_w + dvy_w * dy_w;
    d2_c  = dx_w * dx_w + dy_w * dy_w;
    rdx_w = NW'(dx_r);
    rdy_w = NW'(dy_r);
    num_x = k_r * rdx_w;
    num_y = k_r * rdy_w;
    abs_x = num_x[NW-1] ? -num_x : num_x;
    abs_y = num_y[NW-1] ? -num_y : num_y;
  end

  // One restoring-divide step per cycle on the magnitudes; sign is applied at the end
  always_comb begin
    rem_sh   = {div_rem, div_quo[NW-1]};
    rem_diff = rem_sh - {1'b0, div_den};
    rem_ge   = ~rem_diff[NW];
    rem_nx   = rem_ge ? rem_diff[NW-1:0] : rem_sh[NW-1:0];
    quo_nx   = {div_quo[NW-2:0], rem_ge};
    q_res    = div_neg ? -signed'(quo_nx) : signed'(quo_nx);
    div_last = (div_cnt == CW'(NW-1));
  end

  always_comb begin
    vix_s = (NW+1)'(vel_x[pi]) + (NW+1)'(qx);
    viy_s = (NW+1)'(vel_y[pi]) + (NW+1)'(qy);
    vjx_s = (NW+1)'(vel_x[pj]) - (NW+1)'(qx);
    vjy_s = (NW+1)'(vel_y[pj]) - (NW+1)'(qy);
    hit    = ballActive[pi] && ballActive[pj] && (d2_r != '0) && (d2_r <= DIAM2) && k_r[NW-1];
    at_end = !(int'(pj) + 1 < NUM_BALLS) && !(int'(pi) + 2 < NUM_BALLS);
    advance = ((state == TEST) && !hit) || (state == UPDATE);
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (startOfFrame) state_nx = LOAD;
      LOAD:    state_nx = (NUM_BALLS < 2) ? DONE : PAIR;
      PAIR:    state_nx = TEST;
      TEST:    state_nx = hit ? DIVX : (at_end ? DONE : PAIR);
      DIVX:    if (div_last) state_nx = DIVY;
      DIVY:    if (div_last) state_nx = UPDATE;
      UPDATE:  state_nx = at_end ? DONE : PAIR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pi <= '0;
      pj <= '0;
    end else if (state == LOAD) begin
      pi <= '0;
      pj <= IW'(1);
    end else if (advance) begin
      if (int'(pj) + 1 < NUM_BALLS) begin
        pj <= pj + 1'b1;
      end else if (int'(pi) + 2 < NUM_BALLS) begin
        pi <= pi + 1'b1;
        pj <= pi + IW'(2);
      end
    end
  end

  // Register file: snapshot in LOAD, pair terms in PAIR, sequential write-back in UPDATE
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int b = 0; b < NUM_BALLS; b++) begin
        pos_x[b] <= '0;
        pos_y[b] <= '0;
        vel_x[b] <= '0;
        vel_y[b] <= '0;
      end
      collisionMask <= '0;
      dx_r <= '0;
      dy_r <= '0;
      d2_r <= '0;
      k_r  <= '0;
    end else begin
      case (state)
        LOAD: begin
          for (int b = 0; b < NUM_BALLS; b++) begin
            pos_x[b] <= ballPosX[b*W +: W];
            pos_y[b] <= ballPosY[b*W +: W];
            vel_x[b] <= ballVelX[b*W +: W];
            vel_y[b] <= ballVelY[b*W +: W];
          end
          collisionMask <= '0;
        end
        PAIR: begin
          dx_r <= dx_c;
          dy_r <= dy_c;
          d2_r <= d2_c;
          k_r  <= k_c;
        end
        UPDATE: begin
          vel_x[pi] <= sat(vix_s);
          vel_y[pi] <= sat(viy_s);
          vel_x[pj] <= sat(vjx_s);
          vel_y[pj] <= sat(vjy_s);
          collisionMask[pi] <= 1'b1;
          collisionMask[pj] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The X divide is armed during TEST and the Y divide is armed as X finishes
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
      div_neg <= 1'b0;
      div_cnt <= '0;
      qx      <= '0;
      qy      <= '0;
    end else begin
      case (state)
        TEST: begin
          div_rem <= '0;
          div_quo <= abs_x;
          div_den <= d2_r;
          div_neg <= num_x[NW-1];
          div_cnt <= '0;
        end
        DIVX: begin
          if (div_last) begin
            qx      <= q_res;
            div_rem <= '0;
            div_quo <= abs_y;
            div_neg <= num_y[NW-1];
            div_cnt <= '0;
          end else begin
            div_rem <= rem_nx;
            div_quo <= quo_nx;
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DIVY: begin
          div_rem <= rem_nx;
          div_quo <= quo_nx;
          div_cnt <= div_cnt + 1'b1;
          if (div_last) qy <= q_res;
        end
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BALLS; b++) begin : g_out
    assign ballVelXOut[b*W +: W] = vel_x[b];
    assign ballVelYOut[b*W +: W] = vel_y[b];
  end

endmodule

// File: tb/tb_ball_collision_engine.sv
// Directed bench for ball_collision_engine with four balls; idle balls sit far away
// so the expected pass latency is 2 + 2 per non-hit pair + 95 per hit pair over six pairs.
module tb_ball_collision_engine;

  localparam int N = 4;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           startOfFrame = 1'b0;
  logic [N-1:0]   ballActive = '0;
  logic [N*W-1:0] ballPosX = '0, ballPosY = '0, ballVelX = '0, ballVelY = '0;
  logic [N*W-1:0] ballVelXOut, ballVelYOut;
  logic [N-1:0]   collisionMask;
  logic           busy, done;

  int vectors = 0;
  int miscompares = 0;

  ball_collision_engine #(.NUM_BALLS(N), .W(W), .BALL_DIAMETER(16)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballActive(ballActive),
    .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
    .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut), .collisionMask(collisionMask),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [W-1:0] ea, eb, ec, ed;
    ea = W'(a); eb = W'(b); ec = W'(c); ed = W'(d);
    return {ed, ec, eb, ea};
  endfunction

  task automatic set_ball(input int b, input int px, input int py, input int vx, input int vy);
    ballPosX[b*W +: W] = W'(px);
    ballPosY[b*W +: W] = W'(py);
    ballVelX[b*W +: W] = W'(vx);
    ballVelY[b*W +: W] = W'(vy);
  endtask

  // Ball 0 at (100,100), ball 1 placed by caller, balls 2 and 3 inactive and far away
  task automatic setup_two(input int p1x, input int p1y, input int v0x, input int v0y,
                           input int v1x, input int v1y);
    ballActive = 4'b0011;
    set_ball(0, 100, 100, v0x, v0y);
    set_ball(1, p1x, p1y, v1x, v1y);
    set_ball(2, 300, 300, 7, -3);
    set_ball(3, 400, 400, -2, 6);
  endtask

  // Pulses start, optionally re-pulses it or drops reset at a given cycle; lat=-1 on timeout
  task automatic run_pass(input int restart_at, input int abort_at, output int lat);
    lat = -1;
    @(negedge clk);
    startOfFrame = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      startOfFrame = (cyc == restart_at);
      if (done) begin
        lat = cyc;
        break;
      end
      if (cyc == abort_at) begin
        resetN = 1'b0;
        lat = -2;
        break;
      end
    end
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({ballVelXOut, ballVelYOut} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_vel: got %h expected 0", {ballVelXOut, ballVelYOut});
    end
    vectors++;
    if (collisionMask !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_mask: got %b expected 0000", collisionMask);
    end
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    resetN = 1'b1;
  endtask

  // Shared body for single-pair scenarios: checks X, Y, mask and latency
  task automatic test_pair(input string name, input int p1x, input int p1y,
                           input int v0x, input int v0y, input int v1x, input int v1y,
                           input int e0x, input int e0y, input int e1x, input int e1y,
                           input logic [N-1:0] active, input logic [N-1:0] emask, input int elat);
    int lat;
    logic [N*W-1:0] ex, ey;
    setup_two(p1x, p1y, v0x, v0y, v1x, v1y);
    ballActive = active;
    ex = pack4(e0x, e1x, 7, -2);
    ey = pack4(e0y, e1y, -3, 6);
    run_pass(0, 0, lat);
    vectors++;
    if (ballVelXOut !== ex) begin
      miscompares++;
      $display("[TB] FAIL %s velx: got %h expected %h", name, ballVelXOut, ex);
    end
    vectors++;
    if (ballVelYOut !== ey) begin
      miscompares++;
      $display("[TB] FAIL %s vely: got %h expected %h", name, ballVelYOut, ey);
    end
    vectors++;
    if (collisionMask !== emask) begin
      miscompares++;
      $display("[TB] FAIL %s mask: got %b expected %b", name, collisionMask, emask);
    end
    vectors++;
    if (lat !== elat) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
  endtask

  task automatic test_head_on();
    test_pair("head_on", 110, 100, 5, 0, 0, 0, 0, 0, 5, 0, 4'b0011, 4'b0011, 107);
  endtask

  task automatic test_separating();
    test_pair("separating", 110, 100, 0, 0, 5, 0, 0, 0, 5, 0, 4'b0011, 4'b0000, 14);
  endtask

  task automatic test_diagonal();
    test_pair("diagonal", 108, 108, 4, 4, 0, 0, 0, 0, 4, 4, 4'b0011, 4'b0011, 107);
  endtask

  // q = (-60*9)/117 = -4.6 -> -4 and (-60*6)/117 = -3.07 -> -3, then the mirrored layout
  task automatic test_truncation();
    test_pair("trunc_neg", 109, 106, 4, 4, 0, 0, 0, 1, 4, 3, 4'b0011, 4'b0011, 107);
    test_pair("trunc_upleft", 91, 94, -4, -4, 0, 0, 0, -1, -4, -3, 4'b0011, 4'b0011, 107);
  endtask

  task automatic test_gating();
    test_pair("inactive", 110, 100, 5, 0, 0, 0, 5, 0, 0, 0, 4'b0001, 4'b0000, 14);
    test_pair("coincident", 100, 100, 5, 0, 0, 0, 5, 0, 0, 0, 4'b0011, 4'b0000, 14);
  endtask

  task automatic test_contact_boundary();
    test_pair("d2_256", 116, 100, 5, 0, 0, 0, 0, 0, 5, 0, 4'b0011, 4'b0011, 107);
    test_pair("d2_257", 116, 101, 5, 0, 0, 0, 5, 0, 0, 0, 4'b0011, 4'b0000, 14);
  endtask

  // k=-24568, q=-1535 on both axes; v0y = 0-1535 clamps to -1024
  task automatic test_saturation();
    test_pair("saturate", 108, 108, 1023, 0, -1024, -1024, -512, -1024, 511, 511,
              4'b0011, 4'b0011, 107);
  endtask

  task automatic test_chain();
    int lat;
    ballActive = 4'b0111;
    set_ball(0, 100, 100, 5, 0);
    set_ball(1, 110, 100, 0, 0);
    set_ball(2, 120, 100, 0, 0);
    set_ball(3, 400, 400, -2, 6);
    run_pass(0, 0, lat);
    vectors++;
    if (ballVelXOut !== pack4(0, 0, 5, -2)) begin
      miscompares++;
      $display("[TB] FAIL chain velx: got %h expected %h", ballVelXOut, pack4(0, 0, 5, -2));
    end
    vectors++;
    if (ballVelYOut !== pack4(0, 0, 0, 6)) begin
      miscompares++;
      $display("[TB] FAIL chain vely: got %h expected %h", ballVelYOut, pack4(0, 0, 0, 6));
    end
    vectors++;
    if (collisionMask !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL chain mask: got %b expected 0111", collisionMask);
    end
    vectors++;
    if (lat !== 200) begin
      miscompares++;
      $display("[TB] FAIL chain latency: got %0d expected 200", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    setup_two(110, 100, 5, 0, 0, 0);
    run_pass(10, 0, lat);
    vectors++;
    if (lat !== 107) begin
      miscompares++;
      $display("[TB] FAIL restart_latency: got %0d expected 107", lat);
    end
    vectors++;
    if (ballVelXOut !== pack4(0, 5, 7, -2)) begin
      miscompares++;
      $display("[TB] FAIL restart_velx: got %h expected %h", ballVelXOut, pack4(0, 5, 7, -2));
    end
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("[TB] FAIL restart_queued: got %0d busy/done cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_pass();
    int lat;
    setup_two(110, 100, 5, 0, 0, 0);
    ballVelX[1*W +: W] = W'(-3);
    run_pass(0, 60, lat);
    #1;
    vectors++;
    if (lat !== -2) begin
      miscompares++;
      $display("[TB] FAIL abort_point: got %0d expected -2", lat);
    end
    vectors++;
    if ({ballVelXOut, ballVelYOut} !== '0) begin
      miscompares++;
      $display("[TB] FAIL abort_vel: got %h expected 0", {ballVelXOut, ballVelYOut});
    end
    vectors++;
    if ({busy, done, collisionMask} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_status: got %b expected 000000", {busy, done, collisionMask});
    end
    @(negedge clk);
    resetN = 1'b1;
    test_head_on();
  endtask

  initial begin
    test_reset();
    test_head_on();
    test_separating();
    test_diagonal();
    test_truncation();
    test_chain();
    test_gating();
    test_contact_boundary();
    test_saturation();
    test_back_to_back();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_collision_engine.md
Name: ball_collision_engine

Overview:
- Multi-ball elastic collision resolver for the billiard hit controller; generalises the two-ball resolver to NUM_BALLS balls with a parametrised width.
- Once per frame it snapshots every ball's position and velocity, then walks all pairs (i<j) in fixed order.
- For each touching, approaching pair it exchanges the normal velocity components (equal mass) using one shared serial divider.
- It then presents the updated velocities plus a per-ball collision mask to the ball movement blocks.

Parameters:
- NUM_BALLS, 4, number of balls; pairs processed = NUM_BALLS*(NUM_BALLS-1)/2.
- W, 11, signed width of each position and velocity component.
- BALL_DIAMETER, 16, contact distance in pixels; a pair is in contact when dx²+dy² <= BALL_DIAMETER².
- NW, 4*W+2, working width of the numerator and the divider; each quotient takes NW cycles.

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  single-cycle pulse that starts one resolution pass.
- ballActive  in  NUM_BALLS  bit b=1 means ball b takes part; pocketed balls are 0.
- ballPosX  in  NUM_BALLS*W  packed signed top-left X positions, ball b at [b*W +: W].
- ballPosY  in  NUM_BALLS*W  packed signed top-left Y positions, same packing.
- ballVelX  in  NUM_BALLS*W  packed signed X velocities, same packing.
- ballVelY  in  NUM_BALLS*W  packed signed Y velocities, same packing.
- ballVelXOut  out  NUM_BALLS*W  resolved X velocities, same packing.
- ballVelYOut  out  NUM_BALLS*W  resolved Y velocities, same packing.
- collisionMask  out  NUM_BALLS  bit b=1 if ball b was updated in the last pass.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset (async, immediate): all velocity registers 0, collisionMask 0, busy 0, done 0, pair indices 0, FSM to IDLE. Reset mid-pass abandons the pass and leaves no partial update visible.
- ballVelXOut/ballVelYOut are driven directly from the internal velocity register file.
- FSM states: IDLE, LOAD, PAIR, TEST, DIVX, DIVY, UPDATE, DONE.
- IDLE: startOfFrame=1 -> LOAD. startOfFrame while busy is ignored, not queued.
- LOAD (1 cycle):
  - Copy all positions and velocities into internal registers; positions are frozen for the whole pass.
  - Clear collisionMask; set i=0, j=1 -> PAIR.
- PAIR (1 cycle): register, from the current register-file velocities:
  - dx = xj-xi, dy = yj-yi;
  - d2 = dx²+dy²;
  - k = (vxj-vxi)*dx + (vyj-vyi)*dy, at full width with no overflow at NW.
- TEST (1 cycle): the pair is a hit iff all of the following hold:
  - ballActive[i] && ballActive[j];
  - d2 != 0 and d2 <= BALL_DIAMETER²;
  - k < 0 (the balls are approaching; k >= 0 means separating or resting, no action).
  - Hit -> DIVX. Otherwise advance the pair.
- DIVX (NW cycles): qx = (k*dx)/d2. DIVY (NW cycles): qy = (k*dy)/d2.
  - Sign-magnitude restoring divide, truncating toward zero.
- UPDATE (1 cycle):
  - vi += qx,qy and vj -= qx,qy, each result saturated to [-2^(W-1), 2^(W-1)-1].
  - Set collisionMask[i] and collisionMask[j]; then advance the pair.
- Pair advance:
  - j+1 < NUM_BALLS -> j++.
  - Else if i+2 < NUM_BALLS -> i++, j = i+1.
  - Else -> DONE.
  - Every transition into PAIR goes through this rule.
- Updates are sequential: later pairs see the velocities already modified by earlier pairs in the same pass.
- DONE (1 cycle): done=1 -> IDLE. Outputs and collisionMask hold until the next LOAD.
- Latency from the cycle startOfFrame is sampled to the done pulse: 2 + 2 per non-hit pair + (3 + 2*NW) per hit pair.
- NUM_BALLS=1: LOAD -> DONE directly; done pulses 2 cycles after start, mask 0.

Test Plan:
- N=2, head-on: p0=(100,100), p1=(110,100), v0=(5,0), v1=(0,0), both active, start -> v0'=(0,0), v1'=(5,0), mask=2'b11, done 97 cycles after start (NW=46).
- N=2, separating: same positions, v0=(0,0), v1=(5,0) -> velocities unchanged, mask=0, done 4 cycles after start.
- N=2, diagonal: p0=(100,100), p1=(108,108), v0=(4,4), v1=(0,0) -> v0'=(0,0), v1'=(4,4); also v0=(-4,-4) against a p1 placed up-left checks truncation toward zero on negative quotients.
- N=3, chain: p=(100,100),(110,100),(120,100), v0=(5,0), others 0 -> final v=(0,0),(0,0),(5,0), mask=3'b111. Pair (0,2) is rejected because d2=400>256.
- Head-on case with ballActive[1]=0 -> no change, mask 0. Coincident positions (d2=0) -> no change.
- Robustness: a second startOfFrame during DIVX is ignored and exactly one done pulse is produced. Asserting resetN low during DIVY -> outputs 0, busy 0 immediately; a new start then resolves correctly.
